// File: rtl/btn_run_ctrl_pkg.sv
// Shared definitions for the push-button run controller: FSM state encodings
// and default timing constants derived from the 27 MHz board clock.
package btn_run_ctrl_pkg;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } btn_state_e;

  localparam int unsigned CLK_HZ              = 27_000_000;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = CLK_HZ / 50;  // 20 ms
  localparam int unsigned DEF_LONG_CYCLES     = CLK_HZ * 2;   // 2 s

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_run_ctrl_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit; reset value is
// parameterised so the chain can rest at the input's idle level.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] ff_q;

  always_ff @(posedge clk) begin
    if (rst) ff_q <= {2{RST_VAL}};
    else     ff_q <= {ff_q[0], d_i};
  end

  assign q_o = ff_q[1];

endmodule

// File: rtl/btn_run_ctrl.sv
// Push-button conditioner: synchronise, debounce, toggle run per accepted press.
// Optional long-press safe stop is built when macro LONG_PRESS_EN is defined.
module btn_run_ctrl
  import btn_run_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic run,
  output logic btn_level,
  output logic press_pulse,
  output logic long_pulse
);

  localparam int unsigned CW = $clog2(max_u(DEBOUNCE_CYCLES, LONG_CYCLES) + 1);
  // The check fires on the cycle whose increment would reach DEBOUNCE_CYCLES-1,
  // giving exactly DEBOUNCE_CYCLES clocks of stable input after the synchroniser.
  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 2);
  localparam logic [CW-1:0] ARM_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic       btn_sync;
  logic       p;
  btn_state_e state_q;
  logic [CW-1:0] cnt_q;
  logic       armed_q, run_q, level_q, press_q;

  sync_2ff #(.RST_VAL(BTN_ACTIVE_LOW ? 1'b1 : 1'b0)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (btn_raw),
    .q_o (btn_sync)
  );

  assign p = BTN_ACTIVE_LOW ? ~btn_sync : btn_sync;

`ifdef LONG_PRESS_EN
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX   = '1;
  // Hold time survives short release bounces so a long press fires once per hold.
  logic [CW-1:0] hold_q;
  logic          long_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
      armed_q <= 1'b0;
      run_q   <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
`ifdef LONG_PRESS_EN
      hold_q  <= '0;
      long_q  <= 1'b0;
`endif
    end else begin
      press_q <= 1'b0;
`ifdef LONG_PRESS_EN
      long_q  <= 1'b0;
`endif
      case (state_q)
        RELEASED: begin
          if (p) begin
            state_q <= PRESS_CHK;
            cnt_q   <= '0;
          end else if (!armed_q) begin
            if (cnt_q == ARM_LAST) armed_q <= 1'b1;
            else                   cnt_q   <= cnt_q + 1'b1;
          end
        end
        PRESS_CHK: begin
          if (!p) begin
            state_q <= RELEASED;
            cnt_q   <= '0;
          end else if (cnt_q == DB_LAST) begin
            state_q <= PRESSED;
            level_q <= 1'b1;
            cnt_q   <= '0;
`ifdef LONG_PRESS_EN
            hold_q  <= '0;
`endif
            if (armed_q) begin
              press_q <= 1'b1;
              run_q   <= ~run_q;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        PRESSED: begin
          if (!p) begin
            state_q <= RELEASE_CHK;
            cnt_q   <= '0;
          end
`ifdef LONG_PRESS_EN
          else begin
            if (hold_q != CNT_MAX) hold_q <= hold_q + 1'b1;
            if (hold_q == LONG_LAST) begin
              long_q <= 1'b1;
              run_q  <= 1'b0;
            end
          end
`endif
        end
        RELEASE_CHK: begin
          if (p) begin
            state_q <= PRESSED;
          end else if (cnt_q == DB_LAST) begin
            state_q <= RELEASED;
            level_q <= 1'b0;
            armed_q <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= RELEASED;
      endcase
    end
  end

  assign run         = run_q;
  assign btn_level   = level_q;
  assign press_pulse = press_q;
`ifdef LONG_PRESS_EN
  assign long_pulse  = long_q;
`else
  assign long_pulse  = 1'b0;
`endif

endmodule

// File: tb/tb_btn_run_ctrl.sv
// Directed bench for btn_run_ctrl with DEBOUNCE_CYCLES=8, LONG_CYCLES=32, active-low button.
module tb_btn_run_ctrl;

  logic clk = 1'b0;
  logic rst, btn_raw;
  logic run, btn_level, press_pulse, long_pulse;

  int checks = 0;
  int failures = 0;
  int npress = 0;
  int nlong = 0;
  int nboth = 0;
  int np0;
  int nl0;

  always #5 clk = ~clk;

  btn_run_ctrl #(
    .DEBOUNCE_CYCLES(8),
    .LONG_CYCLES    (32),
    .BTN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .run        (run),
    .btn_level  (btn_level),
    .press_pulse(press_pulse),
    .long_pulse (long_pulse)
  );

  always @(negedge clk) begin
    if (press_pulse === 1'b1) npress++;
    if (long_pulse === 1'b1) nlong++;
    if (press_pulse === 1'b1 && long_pulse === 1'b1) nboth++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    // 1: reset with button released
    rst = 1'b1; btn_raw = 1'b1;
    tick(3);
    chk("rst_run", run, 0);
    chk("rst_level", btn_level, 0);
    chk("rst_press", press_pulse, 0);
    chk("rst_long", long_pulse, 0);
    rst = 1'b0;
    tick(20);
    chk("idle_run", run, 0);
    chk("idle_level", btn_level, 0);
    chk("idle_npress", npress, 0);

    // 2: press, release, press again
    btn_raw = 1'b0;
    tick(9);
    chk("p1_early_level", btn_level, 0);
    chk("p1_early_run", run, 0);
    tick(1);
    chk("p1_level", btn_level, 1);
    chk("p1_pulse", press_pulse, 1);
    chk("p1_run", run, 1);
    tick(1);
    chk("p1_pulse_end", press_pulse, 0);
    tick(19);
    btn_raw = 1'b1;
    tick(9);
    chk("r1_early_level", btn_level, 1);
    tick(1);
    chk("r1_level", btn_level, 0);
    chk("r1_run", run, 1);
    tick(20);
    btn_raw = 1'b0;
    tick(10);
    chk("p2_pulse", press_pulse, 1);
    chk("p2_run", run, 0);
    tick(20);
    btn_raw = 1'b1;
    tick(30);
    chk("r2_level", btn_level, 0);
    chk("p2_npress", npress, 2);

    // 3: bounce with 3-cycle plateaus
    for (int i = 0; i < 40; i++) begin
      btn_raw = ((i / 3) % 2 == 0) ? 1'b0 : 1'b1;
      tick(1);
    end
    btn_raw = 1'b1;
    tick(20);
    chk("bnc_npress", npress, 2);
    chk("bnc_run", run, 0);
    chk("bnc_level", btn_level, 0);

    // press to get run=1 again
    btn_raw = 1'b0;
    tick(10);
    chk("p3_pulse", press_pulse, 1);
    chk("p3_run", run, 1);
    tick(20);
    btn_raw = 1'b1;
    tick(30);

    // 6: reset in PRESS_CHK with cnt=5
    btn_raw = 1'b0;
    tick(8);
    chk("chk_level", btn_level, 0);
    chk("chk_run", run, 1);
    rst = 1'b1;
    tick(1);
    chk("mid_rst_run", run, 0);
    chk("mid_rst_level", btn_level, 0);
    chk("mid_rst_press", press_pulse, 0);
    chk("mid_rst_npress", npress, 3);

    // 4: button held through reset deassertion
    tick(2);
    rst = 1'b0;
    np0 = npress;
    tick(50);
    chk("held_npress", npress, np0);
    chk("held_run", run, 0);
    chk("held_level", btn_level, 1);
    btn_raw = 1'b1;
    tick(30);
    chk("held_rel_level", btn_level, 0);
    btn_raw = 1'b0;
    tick(10);
    chk("arm_pulse", press_pulse, 1);
    chk("arm_run", run, 1);
    tick(20);
    btn_raw = 1'b1;
    tick(30);
    btn_raw = 1'b0;
    tick(10);
    chk("pre5_run", run, 0);
    tick(20);
    btn_raw = 1'b1;
    tick(30);

    // 5: long hold from run=0
    np0 = npress;
    nl0 = nlong;
    btn_raw = 1'b0;
    tick(10);
    chk("lp_pulse", press_pulse, 1);
    chk("lp_run", run, 1);
    chk("lp_long0", long_pulse, 0);
    tick(31);
    chk("lp_long_early", long_pulse, 0);
    tick(1);
`ifdef LONG_PRESS_EN
    chk("lp_long", long_pulse, 1);
    chk("lp_run_stop", run, 0);
`else
    chk("lp_long", long_pulse, 0);
    chk("lp_run_stop", run, 1);
`endif
    tick(1);
    chk("lp_long_end", long_pulse, 0);
    tick(17);
    btn_raw = 1'b1;
    tick(30);
    chk("lp_npress", npress - np0, 1);
`ifdef LONG_PRESS_EN
    chk("lp_nlong", nlong - nl0, 1);
    chk("lp_run_final", run, 0);
`else
    chk("lp_nlong", nlong - nl0, 0);
    chk("lp_run_final", run, 1);
`endif
    chk("both_pulses", nboth, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
